// File: rtl/apb_irq_ctrl_pkg.sv
// apb_irq_ctrl_pkg
// Shared definitions for the APB interrupt / sleep controller:
//   - register offsets, expressed as the word index seen on PADDR[4:2]
//   - sleep FSM state encoding (also the value read back from SLEEP[1:0])
//   - field positions inside the ID register
//   - helper that builds the mask of implemented line bits
package apb_irq_ctrl_pkg;

    localparam logic [2:0] OFF_MASK    = 3'd0;
    localparam logic [2:0] OFF_PENDING = 3'd1;
    localparam logic [2:0] OFF_CLEAR   = 3'd2;
    localparam logic [2:0] OFF_MODE    = 3'd3;
    localparam logic [2:0] OFF_ID      = 3'd4;
    localparam logic [2:0] OFF_SLEEP   = 3'd5;

    localparam int ID_REQ_POS  = 31;
    localparam int ID_ID_LSB   = 0;
    localparam int ID_ID_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_state_e;

    // One bit set for every implemented request line; bits above n stay 0.
    function automatic logic [31:0] line_mask(input int n);
        logic [63:0] wide;
        wide = (64'd1 << n) - 64'd1;
        return wide[31:0];
    endfunction

endpackage

// File: rtl/apb_irq_ctrl_line_sync.sv
// irq_line_sync
// Per-line front end: optional 2-flop synchroniser, a delay flop for edge
// detection, and a one-cycle set request selected by the line's MODE bit.
// Ports:
//   clk, rst    block clock and asynchronous active-high reset
//   line        raw request line
//   edge_mode   1 = set on rising edge, 0 = set while high
//   set_pulse   request to set this line's pending bit this cycle
module irq_line_sync
    import apb_irq_ctrl_pkg::*;
#(
    parameter int SYNC_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    input  logic edge_mode,
    output logic set_pulse
);

    logic sync;
    logic dly_q;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic meta_q;
            logic stable_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q   <= 1'b0;
                    stable_q <= 1'b0;
                end else begin
                    meta_q   <= line;
                    stable_q <= meta_q;
                end
            end

            assign sync = stable_q;
        end else begin : g_nosync
            assign sync = line;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= sync;
        end
    end

    assign set_pulse = edge_mode ? (sync & ~dly_q) : sync;

endmodule

// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl
// APB slave interrupt controller with N_LINES request lines, per-line
// edge/level capture, masking, lowest-index priority and a core sleep FSM.
// Ports:
//   HCLK, HRESET             clock, asynchronous active-high reset
//   PADDR..PSLVERR           APB slave (zero wait states, PREADY tied high)
//   line_i                   request lines
//   irq_req_o, irq_id_o      pending request and its index to the core
//   irq_ack_i, irq_ack_id_i  core acknowledge and acknowledged index
//   core_busy_i              core activity, blocks DRAIN -> SLEEP
//   fetch_en_o               core fetch enable
//   clk_gate_core_o          core clock enable, 1 = running
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_LINES        = 32,
    parameter int WAKE_CYCLES    = 4,
    parameter int SYNC_EN        = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_LINES-1:0]        line_i,
    output logic                      irq_req_o,
    output logic [4:0]                irq_id_o,
    input  logic                      irq_ack_i,
    input  logic [4:0]                irq_ack_id_i,
    input  logic                      core_busy_i,
    output logic                      fetch_en_o,
    output logic                      clk_gate_core_o
);

    localparam logic [31:0] LINE_MASK = line_mask(N_LINES);
    localparam logic [3:0]  WAKE_LAST = 4'(WAKE_CYCLES - 1);

    logic [31:0]  mask_q;
    logic [31:0]  mode_q;
    logic [31:0]  pending_q;
    logic [31:0]  pending_d;
    logic [31:0]  line_set;
    logic [31:0]  sw_set;
    logic [31:0]  sw_clr;
    logic [31:0]  ack_clr;
    logic [31:0]  enabled;
    logic         any_enabled;
    logic [2:0]   reg_sel;
    logic         apb_access;
    logic         apb_wr;
    logic [31:0]  rdata;
    logic [3:0]   wake_cnt_q;
    sleep_state_e state_q;
    sleep_state_e state_d;
    logic         unused_addr;

    assign reg_sel     = PADDR[4:2];
    assign apb_access  = PSEL & PENABLE;
    assign apb_wr      = apb_access & PWRITE;
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_line
            if (gi < N_LINES) begin : g_used
                irq_line_sync #(
                    .SYNC_EN(SYNC_EN)
                ) u_sync (
                    .clk      (HCLK),
                    .rst      (HRESET),
                    .line     (line_i[gi]),
                    .edge_mode(mode_q[gi]),
                    .set_pulse(line_set[gi])
                );
            end else begin : g_unused
                assign line_set[gi] = 1'b0;
            end
        end
    endgenerate

    // An out-of-range ack index shifts into a bit above N_LINES, which the
    // final LINE_MASK drops, so no explicit range check is needed.
    assign sw_set  = (apb_wr && reg_sel == OFF_PENDING) ? PWDATA : 32'd0;
    assign sw_clr  = (apb_wr && reg_sel == OFF_CLEAR)   ? PWDATA : 32'd0;
    assign ack_clr = irq_ack_i ? (32'd1 << irq_ack_id_i) : 32'd0;

    // Set sources are ORed in after clearing so that set wins a same-cycle race.
    assign pending_d = ((pending_q & ~(sw_clr | ack_clr)) | line_set | sw_set) & LINE_MASK;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mask_q    <= 32'd0;
            mode_q    <= 32'd0;
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
            if (apb_wr && reg_sel == OFF_MASK) begin
                mask_q <= PWDATA & LINE_MASK;
            end
            if (apb_wr && reg_sel == OFF_MODE) begin
                mode_q <= PWDATA & LINE_MASK;
            end
        end
    end

    assign enabled     = pending_q & mask_q;
    assign any_enabled = |enabled;
    assign irq_req_o   = any_enabled;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        irq_id_o = 5'd0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                irq_id_o = 5'(i);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= RUN;
            wake_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= (state_q == WAKE) ? wake_cnt_q + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (apb_wr && reg_sel == OFF_SLEEP && PWDATA[0] && !any_enabled) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (any_enabled) begin
                    state_d = RUN;
                end else if (!core_busy_i) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (any_enabled) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign clk_gate_core_o = (state_q != SLEEP);
    assign fetch_en_o      = (state_q == RUN) || (state_q == DRAIN);

    always_comb begin
        rdata = 32'd0;
        if (PSEL) begin
            case (reg_sel)
                OFF_MASK:    rdata = mask_q;
                OFF_PENDING: rdata = pending_q;
                OFF_MODE:    rdata = mode_q;
                OFF_ID: begin
                    rdata[ID_REQ_POS]                       = irq_req_o;
                    rdata[ID_ID_LSB +: ID_ID_WIDTH]         = irq_id_o;
                end
                OFF_SLEEP:   rdata[1:0] = state_q;
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign PRDATA  = rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = apb_access && (reg_sel[2:1] == 2'b11);

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// tb_apb_irq_ctrl
// Directed bench for apb_irq_ctrl: a default instance (32 lines, synchronised,
// WAKE_CYCLES = 4) and an 8-line instance for the implemented-width checks.
module tb_apb_irq_ctrl;

    logic        HCLK;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;

    logic        psel_a, psel_b;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        pslverr_a, pslverr_b;
    logic [31:0] line_a;
    logic [7:0]  line_b;
    logic        ack_a, ack_b;
    logic [4:0]  ack_id_a, ack_id_b;
    logic        busy;
    logic        req_a, req_b;
    logic [4:0]  id_a, id_b;
    logic        fetch_a, fetch_b;
    logic        gate_a, gate_b;

    logic        tgt_b;
    logic [31:0] rd;
    logic        err;
    int          checks;
    int          passes;

    apb_irq_ctrl dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(psel_a), .PENABLE(PENABLE), .PRDATA(prdata_a),
        .PREADY(pready_a), .PSLVERR(pslverr_a), .line_i(line_a),
        .irq_req_o(req_a), .irq_id_o(id_a), .irq_ack_i(ack_a),
        .irq_ack_id_i(ack_id_a), .core_busy_i(busy), .fetch_en_o(fetch_a),
        .clk_gate_core_o(gate_a)
    );

    apb_irq_ctrl #(.N_LINES(8)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(psel_b), .PENABLE(PENABLE), .PRDATA(prdata_b),
        .PREADY(pready_b), .PSLVERR(pslverr_b), .line_i(line_b),
        .irq_req_o(req_b), .irq_id_o(id_b), .irq_ack_i(ack_b),
        .irq_ack_id_i(ack_id_b), .core_busy_i(1'b0), .fetch_en_o(fetch_b),
        .clk_gate_core_o(gate_b)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Write completes at the rising edge inside the task; returns on the
    // falling edge right after that edge.
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        PADDR = addr; PWDATA = data; PWRITE = 1'b1; PENABLE = 1'b0;
        if (tgt_b) psel_b = 1'b1; else psel_a = 1'b1;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr);
        @(negedge HCLK);
        PADDR = addr; PWRITE = 1'b0; PENABLE = 1'b0;
        if (tgt_b) psel_b = 1'b1; else psel_a = 1'b1;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        rd  = tgt_b ? prdata_b : prdata_a;
        err = tgt_b ? pslverr_b : pslverr_a;
        @(negedge HCLK);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++; if (gate_a !== 1'b1) $display("[TB] FAIL rst_gate: got %b required %b", gate_a, 1'b1); else passes++;
        checks++; if (fetch_a !== 1'b1) $display("[TB] FAIL rst_fetch: got %b required %b", fetch_a, 1'b1); else passes++;
        checks++; if (req_a !== 1'b0) $display("[TB] FAIL rst_req: got %b required %b", req_a, 1'b0); else passes++;
        checks++; if (id_a !== 5'd0) $display("[TB] FAIL rst_id: got %0d required %0d", id_a, 0); else passes++;
        checks++; if (pslverr_a !== 1'b0) $display("[TB] FAIL rst_slverr: got %b required %b", pslverr_a, 1'b0); else passes++;
        checks++; if (prdata_a !== 32'd0) $display("[TB] FAIL rst_prdata: got %h required %h", prdata_a, 32'd0); else passes++;
        HRESET = 1'b0;
        apb_read(12'h004);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL rst_pending: got %h required %h", rd, 32'd0); else passes++;
        apb_read(12'h014);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL rst_state: got %h required %h", rd, 32'd0); else passes++;
        checks++; if (pready_a !== 1'b1) $display("[TB] FAIL pready: got %b required %b", pready_a, 1'b1); else passes++;
    endtask

    task automatic test_edge();
        apb_write(12'h00C, 32'h1);
        apb_write(12'h000, 32'h1);
        @(negedge HCLK); line_a[0] = 1'b1;
        @(negedge HCLK); line_a[0] = 1'b0;
        @(negedge HCLK);
        checks++; if (req_a !== 1'b0) $display("[TB] FAIL edge_early: got %b required %b", req_a, 1'b0); else passes++;
        @(negedge HCLK);
        checks++; if (req_a !== 1'b1) $display("[TB] FAIL edge_req: got %b required %b", req_a, 1'b1); else passes++;
        checks++; if (id_a !== 5'd0) $display("[TB] FAIL edge_id: got %0d required %0d", id_a, 0); else passes++;
        ack_a = 1'b1; ack_id_a = 5'd0;
        @(negedge HCLK); ack_a = 1'b0;
        checks++; if (req_a !== 1'b0) $display("[TB] FAIL edge_ack: got %b required %b", req_a, 1'b0); else passes++;
        repeat (3) @(negedge HCLK);
        checks++; if (req_a !== 1'b0) $display("[TB] FAIL edge_stay: got %b required %b", req_a, 1'b0); else passes++;
    endtask

    task automatic test_priority();
        apb_write(12'h00C, 32'hFF);
        apb_write(12'h000, 32'hFF);
        @(negedge HCLK); line_a[5] = 1'b1; line_a[2] = 1'b1;
        @(negedge HCLK); line_a[5] = 1'b0; line_a[2] = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++; if (id_a !== 5'd2) $display("[TB] FAIL prio_first: got %0d required %0d", id_a, 2); else passes++;
        apb_read(12'h010);
        checks++; if (rd !== 32'h8000_0002) $display("[TB] FAIL prio_idreg: got %h required %h", rd, 32'h8000_0002); else passes++;
        @(negedge HCLK); ack_a = 1'b1; ack_id_a = 5'd2;
        @(negedge HCLK); ack_a = 1'b0;
        checks++; if (id_a !== 5'd5) $display("[TB] FAIL prio_next: got %0d required %0d", id_a, 5); else passes++;
        ack_a = 1'b1; ack_id_a = 5'd5;
        @(negedge HCLK); ack_a = 1'b0;
        checks++; if (req_a !== 1'b0) $display("[TB] FAIL prio_done: got %b required %b", req_a, 1'b0); else passes++;
    endtask

    task automatic test_level();
        apb_write(12'h00C, 32'h0);
        line_a[3] = 1'b1;
        repeat (3) @(negedge HCLK);
        apb_write(12'h008, 32'h8);
        apb_read(12'h004);
        checks++; if (rd !== 32'h8) $display("[TB] FAIL level_hold: got %h required %h", rd, 32'h8); else passes++;
        line_a[3] = 1'b0;
        repeat (4) @(negedge HCLK);
        apb_write(12'h008, 32'h8);
        apb_read(12'h004);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL level_clear: got %h required %h", rd, 32'h0); else passes++;
    endtask

    task automatic test_race();
        apb_write(12'h00C, 32'h2);
        // Line rises before edge k; its set pulse and the CLEAR access both hit edge k+2.
        @(negedge HCLK); line_a[1] = 1'b1;
        @(negedge HCLK); line_a[1] = 1'b0;
        PADDR = 12'h008; PWDATA = 32'h2; PWRITE = 1'b1; PENABLE = 1'b0; psel_a = 1'b1;
        @(negedge HCLK); PENABLE = 1'b1;
        @(negedge HCLK); psel_a = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(12'h004);
        checks++; if (rd !== 32'h2) $display("[TB] FAIL race_pending: got %h required %h", rd, 32'h2); else passes++;
        checks++; if (id_a !== 5'd1) $display("[TB] FAIL race_id: got %0d required %0d", id_a, 1); else passes++;
        apb_write(12'h008, 32'h2);
        apb_read(12'h004);
        checks++; if (rd !== 32'h0) $display("[TB] FAIL race_clear: got %h required %h", rd, 32'h0); else passes++;
    endtask

    task automatic test_sleep();
        apb_write(12'h000, 32'h0);
        apb_write(12'h00C, 32'h10);
        apb_write(12'h008, 32'hFFFF_FFFF);
        busy = 1'b1;
        apb_write(12'h014, 32'h1);
        apb_read(12'h014);
        checks++; if (rd !== 32'd1) $display("[TB] FAIL sleep_drain: got %0d required %0d", rd, 1); else passes++;
        checks++; if (gate_a !== 1'b1) $display("[TB] FAIL drain_gate: got %b required %b", gate_a, 1'b1); else passes++;
        busy = 1'b0;
        @(negedge HCLK);
        checks++; if (gate_a !== 1'b0) $display("[TB] FAIL sleep_gate: got %b required %b", gate_a, 1'b0); else passes++;
        checks++; if (fetch_a !== 1'b0) $display("[TB] FAIL sleep_fetch: got %b required %b", fetch_a, 1'b0); else passes++;
        @(negedge HCLK); line_a[4] = 1'b1;
        @(negedge HCLK); line_a[4] = 1'b0;
        repeat (4) @(negedge HCLK);
        apb_read(12'h014);
        checks++; if (rd !== 32'd2) $display("[TB] FAIL masked_nowake: got %0d required %0d", rd, 2); else passes++;
        apb_read(12'h004);
        checks++; if (rd !== 32'h10) $display("[TB] FAIL masked_pending: got %h required %h", rd, 32'h10); else passes++;
        apb_write(12'h000, 32'h10);
        checks++; if (gate_a !== 1'b0) $display("[TB] FAIL wake_w0: got %b required %b", gate_a, 1'b0); else passes++;
        @(negedge HCLK);
        checks++; if (gate_a !== 1'b1) $display("[TB] FAIL wake_gate: got %b required %b", gate_a, 1'b1); else passes++;
        checks++; if (fetch_a !== 1'b0) $display("[TB] FAIL wake_fetch0: got %b required %b", fetch_a, 1'b0); else passes++;
        repeat (3) @(negedge HCLK);
        checks++; if (fetch_a !== 1'b0) $display("[TB] FAIL wake_fetch3: got %b required %b", fetch_a, 1'b0); else passes++;
        @(negedge HCLK);
        checks++; if (fetch_a !== 1'b1) $display("[TB] FAIL wake_fetch4: got %b required %b", fetch_a, 1'b1); else passes++;
        apb_write(12'h014, 32'h1);
        apb_read(12'h014);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL sleep_ignored: got %0d required %0d", rd, 0); else passes++;
        checks++; if (id_a !== 5'd4) $display("[TB] FAIL wake_id: got %0d required %0d", id_a, 4); else passes++;
    endtask

    task automatic test_errors_reset();
        apb_read(12'h018);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err18_slverr: got %b required %b", err, 1'b1); else passes++;
        checks++; if (rd !== 32'd0) $display("[TB] FAIL err18_data: got %h required %h", rd, 32'd0); else passes++;
        apb_read(12'h01C);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err1c_slverr: got %b required %b", err, 1'b1); else passes++;
        apb_read(12'h000);
        checks++; if (err !== 1'b0) $display("[TB] FAIL ok_slverr: got %b required %b", err, 1'b0); else passes++;
        checks++; if (rd !== 32'h10) $display("[TB] FAIL mask_read: got %h required %h", rd, 32'h10); else passes++;

        tgt_b = 1'b1;
        apb_write(12'h004, 32'h0000_FFFF);
        apb_read(12'h004);
        checks++; if (rd !== 32'h0000_00FF) $display("[TB] FAIL n8_pending: got %h required %h", rd, 32'h0000_00FF); else passes++;
        @(negedge HCLK); ack_b = 1'b1; ack_id_b = 5'd8;
        @(negedge HCLK); ack_b = 1'b0;
        apb_read(12'h004);
        checks++; if (rd !== 32'h0000_00FF) $display("[TB] FAIL n8_ack_oob: got %h required %h", rd, 32'h0000_00FF); else passes++;
        @(negedge HCLK); ack_b = 1'b1; ack_id_b = 5'd3;
        @(negedge HCLK); ack_b = 1'b0;
        apb_read(12'h004);
        checks++; if (rd !== 32'h0000_00F7) $display("[TB] FAIL n8_ack3: got %h required %h", rd, 32'h0000_00F7); else passes++;
        tgt_b = 1'b0;

        apb_write(12'h000, 32'h0);
        apb_write(12'h008, 32'hFFFF_FFFF);
        apb_write(12'h014, 32'h1);
        @(negedge HCLK);
        checks++; if (gate_a !== 1'b0) $display("[TB] FAIL presleep_gate: got %b required %b", gate_a, 1'b0); else passes++;
        #2 HRESET = 1'b1;
        #1;
        checks++; if (gate_a !== 1'b1) $display("[TB] FAIL rstsleep_gate: got %b required %b", gate_a, 1'b1); else passes++;
        checks++; if (fetch_a !== 1'b1) $display("[TB] FAIL rstsleep_fetch: got %b required %b", fetch_a, 1'b1); else passes++;
        @(negedge HCLK); HRESET = 1'b0;
        apb_read(12'h014);
        checks++; if (rd !== 32'd0) $display("[TB] FAIL rstsleep_state: got %0d required %0d", rd, 0); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PENABLE = 1'b0;
        psel_a = 1'b0; psel_b = 1'b0; line_a = '0; line_b = '0;
        ack_a = 1'b0; ack_b = 1'b0; ack_id_a = '0; ack_id_b = '0;
        busy = 1'b0; tgt_b = 1'b0; rd = '0; err = 1'b0;

        test_reset();
        test_edge();
        test_priority();
        test_level();
        test_race();
        test_sleep();
        test_errors_reset();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
